// File: rtl/aes_mixcol_pkg.sv
// Shared GF(2^8) helpers and FSM encoding for the MixColumns engine.
package aes_mixcol_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return gf_xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return gf_xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulB(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulD(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(gf_xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulE(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(gf_xtime(a)) ^ gf_xtime(a);
  endfunction
endpackage

// File: rtl/aes_mixcol_col.sv
// One MixColumns / InvMixColumns column; byte 0 is the MSB byte of col_i.
module aes_mixcol_col
  import aes_mixcol_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);
  logic [3:0][7:0] a, fwd, inv;

  assign a = col_i;

  // a[3-i] holds byte i, so rotations index from the top.
  always_comb begin
    fwd = '0;
    inv = '0;
    for (int i = 0; i < 4; i++) begin
      fwd[3-i] = gf_mul2(a[3-i]) ^ gf_mul3(a[3-((i+1)%4)]) ^
                 a[3-((i+2)%4)] ^ a[3-((i+3)%4)];
      inv[3-i] = gf_mulE(a[3-i]) ^ gf_mulB(a[3-((i+1)%4)]) ^
                 gf_mulD(a[3-((i+2)%4)]) ^ gf_mul9(a[3-((i+3)%4)]);
    end
  end

  assign col_o = (INV_EN && inv_i) ? inv : fwd;
endmodule

// File: rtl/aes_mixcol_engine.sv
// Multi-cycle MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock,
// valid/ready on both sides, uniform latency including bypass.
module aes_mixcol_engine
  import aes_mixcol_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int C    = COLS_PER_CYCLE;
  localparam int NCYC = 4 / C;

  generate
    if (C != 1 && C != 2 && C != 4) begin : g_bad_cols
      $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [3:0][31:0]   work_q, work_d;  // work_q[3] is column 0
  logic               inv_q, inv_d;
  logic               byp_q, byp_d;

  logic [C-1:0][1:0]  col_idx;
  logic [C-1:0][31:0] col_in, col_out;
  logic               accept;

  generate
    for (genvar k = 0; k < C; k++) begin : g_col
      assign col_idx[k] = 2'(int'(cnt_q) * C + k);
      assign col_in[k]  = work_q[2'd3 - col_idx[k]];
      aes_mixcol_col #(.INV_EN(INV_EN)) u_col (
        .col_i (col_in[k]),
        .inv_i (inv_q),
        .col_o (col_out[k])
      );
    end
  endgenerate

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = work_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    case (state_q)
      BUSY: begin
        if (!byp_q) begin
          for (int k = 0; k < C; k++) work_d[2'd3 - col_idx[k]] = col_out[k];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(NCYC - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Acceptance from IDLE or from DONE on the same edge the result drains.
    if (accept) begin
      work_d  = in_state;
      inv_d   = in_inv & INV_EN;
      byp_d   = in_bypass;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
    end
  end
endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Directed bench: four engine builds (C=1, C=2, C=4, C=1 without inverse).
module tb_aes_mixcol_engine;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         iv, ir, iinv, ibyp, ov, ordy, bsy;
  logic [3:0][127:0]  ist, ost;
  int checks = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] D4_IN    = {4{32'hd4d4d4d5}};
  localparam logic [127:0] D5_OUT   = {4{32'hd5d5d7d6}};

  always #5 clk = ~clk;

  aes_mixcol_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .in_inv(iinv[0]), .in_bypass(ibyp[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_state(ost[0]), .busy(bsy[0]));
  aes_mixcol_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .in_inv(iinv[1]), .in_bypass(ibyp[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_state(ost[1]), .busy(bsy[1]));
  aes_mixcol_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .in_inv(iinv[2]), .in_bypass(ibyp[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_state(ost[2]), .busy(bsy[2]));
  aes_mixcol_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u_noinv (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_state(ist[3]),
    .in_inv(iinv[3]), .in_bypass(ibyp[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_state(ost[3]), .busy(bsy[3]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one state to DUT d, measure edges until out_valid, check result, drain.
  task automatic run(input int d, input logic [127:0] st, input logic inv, input logic byp,
                     input logic [127:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, 128'(ir[d]), 128'd1);
    iv[d] = 1'b1; ist[d] = st; iinv[d] = inv; ibyp[d] = byp;
    @(posedge clk); #1;
    iv[d] = 1'b0; iinv[d] = ~inv; ibyp[d] = ~byp;  // must be ignored after acceptance
    n = 0;
    while (n < 8 && !ov[d]) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_out"}, ost[d], exp);
    @(posedge clk); #1;
    iinv[d] = 1'b0; ibyp[d] = 1'b0;
  endtask

  initial begin
    iv = '0; iinv = '0; ibyp = '0; ordy = '1; ist = '0;
    #12;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_rdy%0d", d), 128'(ir[d]), 128'd1);
      check($sformatf("rst_ov%0d", d),  128'(ov[d]), 128'd0);
      check($sformatf("rst_bsy%0d", d), 128'(bsy[d]), 128'd0);
      check($sformatf("rst_ost%0d", d), ost[d], 128'd0);
    end
    @(negedge clk); rst = 1'b0;

    run(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 4, "fwd_c1");
    run(2, INV_IN,  1'b1, 1'b0, INV_OUT,  1, "inv_c4");
    run(1, BYP_IN,  1'b0, 1'b1, BYP_IN,   2, "byp_c2");
    run(1, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 2, "fwd_c2");
    run(1, INV_IN,  1'b1, 1'b0, INV_OUT,  2, "inv_c2");
    run(2, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 1, "fwd_c4");
    run(0, INV_IN,  1'b1, 1'b0, INV_OUT,  4, "inv_c1");
    run(0, D4_IN,   1'b0, 1'b1, D4_IN,    4, "byp_c1");
    run(3, FIPS_IN, 1'b1, 1'b0, FIPS_OUT, 4, "noinv");

    // Backpressure in DONE, then same-cycle accept on release.
    ordy[0] = 1'b0;
    @(negedge clk); iv[0] = 1'b1; ist[0] = FIPS_IN; iinv[0] = 1'b0; ibyp[0] = 1'b0;
    @(posedge clk); #1; iv[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("bp_ov", 128'(ov[0]), 128'd1);
    check("bp_out", ost[0], FIPS_OUT);
    iv[0] = 1'b1; ist[0] = D4_IN;  // offered while stalled: must not be taken
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold", ost[0], FIPS_OUT);
      check("bp_rdy", 128'(ir[0]), 128'd0);
      check("bp_ovh", 128'(ov[0]), 128'd1);
    end
    @(negedge clk); ordy[0] = 1'b1; #1;
    check("bp_rdy_comb", 128'(ir[0]), 128'd1);
    @(posedge clk); #1; iv[0] = 1'b0;
    check("bp_busy", 128'(bsy[0]), 128'd1);
    check("bp_ov_drop", 128'(ov[0]), 128'd0);
    repeat (3) @(posedge clk); #1;
    check("bp_ov_early", 128'(ov[0]), 128'd0);
    @(posedge clk); #1;
    check("bp_ov2", 128'(ov[0]), 128'd1);
    check("bp_out2", ost[0], D5_OUT);
    @(posedge clk); #1;

    // Reset during the second BUSY cycle discards the state in flight.
    @(negedge clk); iv[0] = 1'b1; ist[0] = FIPS_IN;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(posedge clk); #2; rst = 1'b1; #1;
    check("mid_ov", 128'(ov[0]), 128'd0);
    check("mid_rdy", 128'(ir[0]), 128'd1);
    check("mid_bsy", 128'(bsy[0]), 128'd0);
    check("mid_ost", ost[0], 128'd0);
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("mid_no_out", 128'(ov[0]), 128'd0);
    end
    run(0, D4_IN, 1'b0, 1'b0, D5_OUT, 4, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_mixcol_engine.md
Name: aes_mixcol_engine

Overview:
Multi-cycle MixColumns / InvMixColumns engine for the AES round datapath. It accepts a full 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state with the same handshake. It replaces the purely combinational single-word mixer and adds inverse mode, a bypass for the final round, and throughput/area scaling.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal 1, 2, 4; any other value is an elaboration error.
INV_EN, 1, 1 instantiates InvMixColumns logic; 0 removes it and forces forward mode.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  input state valid.
in_ready  output  1  engine can accept a state.
in_state  input  128  state; column c = bits [127-32c -: 32]; byte 0 of a column is the MSB byte.
in_inv  input  1  1 = InvMixColumns (ignored when INV_EN=0).
in_bypass  input  1  1 = pass the state unchanged (final AES round).
out_valid  output  1  out_state valid.
out_ready  input  1  downstream accepts out_state.
out_state  output  128  transformed state, same column/byte layout.
busy  output  1  high while in BUSY.

Behaviour:
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0, latched mode=0.
- States are IDLE, BUSY and DONE. NCYC = 4/COLS_PER_CYCLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_state, in_inv&INV_EN and in_bypass; counter=0; go to BUSY.
- BUSY: each cycle, overwrite columns [counter*C .. counter*C+C-1] of the working register with their transform, then counter += 1. After the NCYC-th cycle, go to DONE.
- DONE: out_valid=1 and out_state=working register, both stable until out_ready.
- On out_ready in DONE: if in_valid also high, accept the new state in the same cycle and go to BUSY; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is never high in BUSY, and it combinationally depends on out_ready.
- Latency: accept at edge t gives out_valid=1 after edge t+NCYC. Sustained throughput is one state per NCYC+1 cycles when out_ready is always 1.
- Forward column transform (a0..a3 → b0..b3): b_i = 2·a_i ⊕ 3·a_{i+1} ⊕ a_{i+2} ⊕ a_{i+3}, indices mod 4.
- Inverse column transform: b_i = 0E·a_i ⊕ 0B·a_{i+1} ⊕ 0D·a_{i+2} ⊕ 09·a_{i+3}.
- All products are in GF(2^8) modulo x^8+x^4+x^3+x+1. xtime(a) = (a<<1) ⊕ (a[7]?8'h1B:0).
- Bypass: the cycle count is identical to the non-bypass path (uniform latency), and the working register is not modified.
- in_inv and in_bypass are sampled only at acceptance. Changes on these inputs while in BUSY or DONE have no effect.
- in_valid while not ready: no effect. The source must hold its data, and the engine latches nothing.
- Asserting rst in any state immediately returns all registers to their reset values. A state in flight is discarded and is never presented on the output.
- out_state does not change while out_valid=1 and out_ready=0.

Decomposition:
- Package aes_mixcol_pkg holds:
  - function gf_xtime(8b→8b);
  - functions gf_mul2, gf_mul3, gf_mul9, gf_mulB, gf_mulD, gf_mulE;
  - localparam AES_POLY=8'h1B;
  - enum state_t {IDLE, BUSY, DONE}.
- One combinational sub-module, aes_mixcol_col (32b in, inv select, 32b out), implements one forward/inverse column. Instantiate COLS_PER_CYCLE copies, muxed onto the column slice selected by the counter.

Test Plan:
- FIPS-197 forward, C=1: in_state=db135345_f20a225c_01010101_c6c6c6c6, inv=0 → out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises exactly 4 cycles after acceptance.
- Inverse, C=4: in_state=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, inv=1 → out_state=db135345_f20a225c_d4d4d4d5_2d26314c; latency 1 cycle.
- Bypass, C=2: in_state=00112233_44556677_8899aabb_ccddeeff, bypass=1 → identical out_state after 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_state stable and in_ready=0. Raise out_ready with in_valid=1 → same-cycle accept, and the next result is correct.
- Reset mid-op: assert rst on the 2nd BUSY cycle (C=1) → out_valid=0 and in_ready=1 immediately. The next state, d4d4d4d5 repeated ×4, yields d5d5d7d6 ×4.
- INV_EN=0 build: in_inv=1 with the FIPS forward vector → forward result 8e4da1bc... is produced.
